pixel_fetch_unit: RTL and testbench

Sequential, parametrised successor to the combinational pixel-address mapper. It accepts (x, y) screen-coordinate requests over a valid/ready handshake and maps them to a packed frame-buffer word address and an in-word position. It then performs the memory read with configurable latency and returns the extracted BPP-bit pixel over a second valid/ready handshake. It sits between the VGA timing/sprite logic and the frame-buffer RAM.

---
 rtl/pixel_fetch_pkg.sv | 28 ++
 rtl/pixel_fetch_unit_addr_calc.sv | 41 ++++
 rtl/pixel_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_pixel_fetch_unit.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared FSM states and frame-buffer geometry helpers
// for the pixel fetch unit and its address mapper.
package pixel_fetch_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        RESP
    } state_e;

    function automatic int ppw(input int word_w, input int bpp);
        return word_w / bpp;
    endfunction

    function automatic int wpl(input int h_active, input int word_w,
                               input int bpp);
        return h_active / ppw(word_w, bpp);
    endfunction

    // One pixel per word still needs a one-bit position port.
    function automatic int pos_w(input int word_w, input int bpp);
        return (ppw(word_w, bpp) > 1) ? $clog2(ppw(word_w, bpp)) : 1;
    endfunction

endpackage

// File: rtl/pixel_fetch_unit_addr_calc.sv
// Combinational (x, y) -> frame-buffer word address, in-word
// position and out-of-range flag; shared with the sprite engine.
module pixel_addr_calc
    import pixel_fetch_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int Y_OFFSET  = 80,
    parameter int BPP       = 1,
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    localparam int PW       = pos_w(WORD_W, BPP)
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic [PW-1:0]      pos,
    output logic               oob
);

    localparam int PPW = ppw(WORD_W, BPP);
    localparam int WPL = wpl(H_ACTIVE, WORD_W, BPP);

    logic [31:0] xw;
    logic [31:0] yw;

    // Row term may wrap for y < Y_OFFSET; oob masks that case.
    always_comb begin
        xw   = 32'(x);
        yw   = 32'(y);
        oob  = (xw >= 32'(H_ACTIVE)) ||
               (yw < 32'(Y_OFFSET)) ||
               (yw >= 32'(V_ACTIVE));
        addr = ADDR_W'(32'(BASE_ADDR) +
                       (yw - 32'(Y_OFFSET)) * 32'(WPL) +
                       xw / 32'(PPW));
        pos  = PW'(xw % 32'(PPW));
    end

endmodule

// File: rtl/pixel_fetch_unit.sv
// Pixel fetch unit: request -> frame-buffer read -> pixel response.
// Define WORD_CACHE_EN for a single-entry word cache with flush.
module pixel_fetch_unit
    import pixel_fetch_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int Y_OFFSET  = 80,
    parameter int BPP       = 1,
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MEM_LAT   = 1,
    localparam int PW       = pos_w(WORD_W, BPP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic               flush,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [WORD_W-1:0]  mem_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BPP-1:0]     rsp_pixel,
    output logic [PW-1:0]      rsp_pos,
    output logic               rsp_oob
);

    localparam int CW = $clog2(MEM_LAT + 1);

    state_e            state;
    state_e            state_nx;
    logic              rdy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PW-1:0]     pos_q;
    logic              oob_q;
    logic [BPP-1:0]    pix_q;
    logic [CW-1:0]     cnt;

    logic [ADDR_W-1:0] c_addr;
    logic [PW-1:0]     c_pos;
    logic              c_oob;
    logic              accept;
    logic              fill;
    logic              hit;
    logic [WORD_W-1:0] hit_word;

    pixel_addr_calc #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .Y_OFFSET  (Y_OFFSET),
        .BPP       (BPP),
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_calc (
        .x    (req_x),
        .y    (req_y),
        .addr (c_addr),
        .pos  (c_pos),
        .oob  (c_oob)
    );

    function automatic logic [BPP-1:0] extract(
        input logic [WORD_W-1:0] w,
        input logic [PW-1:0]     p
    );
        logic [WORD_W-1:0] sh;
        sh = w << (32'(p) * BPP);
        return sh[WORD_W-1 -: BPP];
    endfunction

    assign accept = req_valid && rdy_q && (state == IDLE);
    assign fill   = (state == WAIT) && (cnt == '0);

`ifdef WORD_CACHE_EN
    logic              cache_vld;
    logic [ADDR_W-1:0] cache_tag;
    logic [WORD_W-1:0] cache_word;

    // A same-cycle flush forces the request to miss.
    assign hit      = cache_vld && !flush && !c_oob &&
                      (c_addr == cache_tag);
    assign hit_word = cache_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_word <= '0;
        end else if (flush) begin
            cache_vld <= 1'b0;
        end else if (fill) begin
            cache_vld  <= 1'b1;
            cache_tag  <= addr_q;
            cache_word <= mem_data;
        end
    end
`else
    logic unused_flush;

    assign hit          = 1'b0;
    assign hit_word     = '0;
    assign unused_flush = flush;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rdy_q;
                if (accept) begin
                    state_nx = (c_oob || hit) ? RESP : FETCH;
                end
            end
            FETCH: begin
                mem_rd   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // rdy_q keeps req_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            addr_q <= '0;
            pos_q  <= '0;
            oob_q  <= 1'b0;
            pix_q  <= '0;
            cnt    <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                addr_q <= c_addr;
                pos_q  <= c_pos;
                oob_q  <= c_oob;
                unique case (1'b1)
                    c_oob:   pix_q <= '0;
                    hit:     pix_q <= extract(hit_word, c_pos);
                    default: ;
                endcase
            end
            if (state == FETCH) begin
                cnt <= CW'(MEM_LAT - 1);
            end else if (state == WAIT) begin
                if (cnt == '0) begin
                    pix_q <= extract(mem_data, pos_q);
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign rsp_pixel = pix_q;
    assign rsp_pos   = pos_q;
    assign rsp_oob   = oob_q;

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// Randomised bench for pixel_fetch_unit against a behavioural
// frame-buffer model; also honours WORD_CACHE_EN.
module tb_pixel_fetch_unit;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int YO   = 80;
    localparam int BPP  = 1;
    localparam int WW   = 16;
    localparam int AW   = 16;
    localparam int BASE = 0;
    localparam int LAT  = 1;
    localparam int PPW  = WW / BPP;
    localparam int WPL  = H / PPW;
    localparam int PW   = (PPW > 1) ? $clog2(PPW) : 1;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [10:0]    req_x;
    logic [10:0]    req_y;
    logic           flush;
    logic           mem_rd;
    logic [AW-1:0]  mem_addr;
    logic [WW-1:0]  mem_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [BPP-1:0] rsp_pixel;
    logic [PW-1:0]  rsp_pos;
    logic           rsp_oob;

    pixel_fetch_unit #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .Y_OFFSET  (YO),
        .BPP       (BPP),
        .WORD_W    (WW),
        .ADDR_W    (AW),
        .BASE_ADDR (BASE),
        .MEM_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .flush     (flush),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_pixel (rsp_pixel),
        .rsp_pos   (rsp_pos),
        .rsp_oob   (rsp_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    function automatic void chk(input bit ok, input string nm,
                                input longint act, input longint exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    // Frame-buffer contents: constant pattern or address hash.
    bit mem_mode = 1'b0;

    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a,
                                               input bit mode);
        if (!mode) return 16'h8001;
        return WW'((32'(a) * 32'h9E37) ^ 32'hC3A5);
    endfunction

    bit            pv [LAT];
    logic [AW-1:0] pa [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        pv[0] <= mem_rd;
        pa[0] <= mem_addr;
    end

    assign mem_data = pv[LAT-1] ? mem_word(pa[LAT-1], mem_mode)
                                : 16'h5A5A;

    typedef struct {
        int            pix;
        int            pos;
        int            addr;
        int            lat;
        bit            oob;
        bit            fetch;
        bit            hit;
        logic [WW-1:0] word;
    } exp_t;

`ifdef WORD_CACHE_EN
    bit            mvalid;
    int            maddr;
    logic [WW-1:0] mword;
`endif

    function automatic exp_t predict(input int x, input int y);
        exp_t r;
        r.oob  = (x >= H) || (y < YO) || (y >= V);
        r.addr = (BASE + (y - YO) * WPL + x / PPW) & ((1 << AW) - 1);
        r.pos  = x % PPW;
        r.hit  = 1'b0;
`ifdef WORD_CACHE_EN
        r.hit  = !r.oob && mvalid && !flush && (maddr == r.addr);
        r.word = r.hit ? mword : mem_word(AW'(r.addr), mem_mode);
`else
        r.word = mem_word(AW'(r.addr), mem_mode);
`endif
        r.fetch = !r.oob && !r.hit;
        r.lat   = r.fetch ? 2 + LAT : 1;
        r.pix   = r.oob ? 0 :
                  (int'(r.word >> (WW - (r.pos + 1) * BPP)) &
                   ((1 << BPP) - 1));
        return r;
    endfunction

    bit   pending = 1'b0;
    exp_t e;
    int   ncyc = 0;
    int   t_acc = 0;

    always @(posedge clk or negedge rst_n) begin
        exp_t nx;
        if (!rst_n) begin
            pending <= 1'b0;
`ifdef WORD_CACHE_EN
            mvalid  <= 1'b0;
`endif
        end else begin
            ncyc <= ncyc + 1;
            if (req_valid && req_ready) begin
                nx = predict(int'(req_x), int'(req_y));
                e       <= nx;
                pending <= 1'b1;
                t_acc   <= ncyc;
`ifdef WORD_CACHE_EN
                if (flush) mvalid <= 1'b0;
                if (nx.fetch) begin
                    mvalid <= 1'b1;
                    maddr  <= nx.addr;
                    mword  <= nx.word;
                end
`endif
            end else begin
                if (pending && rsp_valid && rsp_ready) pending <= 1'b0;
`ifdef WORD_CACHE_EN
                if (flush) mvalid <= 1'b0;
`endif
            end
        end
    end

    int since_rst = 0;
    int rd_cnt    = 0;
    int cap_addr  = -1;
    int cap_pix   = -1;
    int cap_pos   = -1;
    int cap_oob   = -1;
    int cap_lat   = -1;
    bit seen      = 1'b0;

    always @(negedge clk) begin
        int cyc;
        if (!rst_n) begin
            since_rst = 0;
        end else begin
            if (since_rst < 3) since_rst++;
            if (mem_rd) begin
                rd_cnt++;
                cap_addr = int'(mem_addr);
            end
            if (pending) begin
                cyc = ncyc - t_acc;
                if (cyc == 1) seen = 1'b0;
                chk(rsp_valid == (cyc >= e.lat), "rsp_valid_timing",
                    rsp_valid, cyc >= e.lat);
                chk(mem_rd == (e.fetch && cyc == 1), "mem_rd_pulse",
                    mem_rd, e.fetch && cyc == 1);
                chk(!req_ready, "req_ready_busy", req_ready, 0);
                if (mem_rd) begin
                    chk(int'(mem_addr) == e.addr, "mem_addr",
                        mem_addr, e.addr);
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen    = 1'b1;
                        cap_lat = cyc;
                    end
                    cap_pix = int'(rsp_pixel);
                    cap_pos = int'(rsp_pos);
                    cap_oob = int'(rsp_oob);
                    chk(int'(rsp_pixel) == e.pix, "rsp_pixel",
                        rsp_pixel, e.pix);
                    chk(int'(rsp_pos) == e.pos, "rsp_pos",
                        rsp_pos, e.pos);
                    chk(rsp_oob == e.oob, "rsp_oob", rsp_oob, e.oob);
                end
            end else if (since_rst >= 2) begin
                chk(!rsp_valid, "idle_rsp_valid", rsp_valid, 0);
                chk(!mem_rd, "idle_mem_rd", mem_rd, 0);
                chk(req_ready, "idle_req_ready", req_ready, 1);
            end
        end
    end

    task automatic reset_zero(input string tag);
        chk(!req_ready, {tag, "_req_ready"}, req_ready, 0);
        chk(!mem_rd, {tag, "_mem_rd"}, mem_rd, 0);
        chk(mem_addr == '0, {tag, "_mem_addr"}, mem_addr, 0);
        chk(!rsp_valid, {tag, "_rsp_valid"}, rsp_valid, 0);
        chk(rsp_pixel == '0, {tag, "_rsp_pixel"}, rsp_pixel, 0);
        chk(rsp_pos == '0, {tag, "_rsp_pos"}, rsp_pos, 0);
        chk(!rsp_oob, {tag, "_rsp_oob"}, rsp_oob, 0);
    endtask

    task automatic do_req(input int x, input int y, input bit fl,
                          input int hold);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(req_ready, "req_ready_timeout", req_ready, 1);
        if (!req_ready) return;
        req_valid = 1'b1;
        req_x     = 11'(x);
        req_y     = 11'(y);
        flush     = fl;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(rsp_valid, "rsp_valid_timeout", rsp_valid, 1);
        if (!rsp_valid) return;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int tx  [8] = '{0, 639, 0, 639, 400, 1, 15, 32};
    int ty  [8] = '{80, 80, 89, 479, 200, 80, 80, 80};
    int ta  [8] = '{0, 39, 360, 15999, 4825, 0, 0, 2};
    int tp  [8] = '{0, 15, 0, 15, 0, 1, 15, 0};
    int tpx [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
    int ox  [3] = '{0, 640, 0};
    int oy  [3] = '{79, 100, 480};

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int px;
        int py;
        int x;
        int y;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        #3;
        reset_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            r0 = rd_cnt;
            do_req(tx[i], ty[i], 1'b1, 0);
            chk(cap_addr == ta[i], "map_addr", cap_addr, ta[i]);
            chk(cap_pos == tp[i], "map_pos", cap_pos, tp[i]);
            chk(cap_pix == tpx[i], "map_pixel", cap_pix, tpx[i]);
            chk(cap_lat == 3, "miss_latency", cap_lat, 3);
            chk(rd_cnt - r0 == 1, "miss_rd_count", rd_cnt - r0, 1);
        end

        for (int i = 0; i < 3; i++) begin
            r0 = rd_cnt;
            do_req(ox[i], oy[i], 1'b0, 0);
            chk(cap_oob == 1, "oob_flag", cap_oob, 1);
            chk(cap_pix == 0, "oob_pixel", cap_pix, 0);
            chk(cap_lat == 1, "oob_latency", cap_lat, 1);
            chk(rd_cnt - r0 == 0, "oob_rd_count", rd_cnt - r0, 0);
        end

        r0 = rd_cnt;
        do_req(15, 80, 1'b1, 5);
        chk(cap_pix == 1, "bp_pixel", cap_pix, 1);
        chk(rd_cnt - r0 == 1, "bp_rd_count", rd_cnt - r0, 1);
        chk(req_ready, "bp_idle_next", req_ready, 1);

        while (!req_ready) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b1;
        req_x     = 11'd0;
        req_y     = 11'd80;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        do_req(0, 80, 1'b1, 0);
        chk(cap_pix == 1, "post_rst_pixel", cap_pix, 1);
        chk(cap_lat == 3, "post_rst_latency", cap_lat, 3);

`ifdef WORD_CACHE_EN
        do_req(0, 80, 1'b1, 0);
        r0 = rd_cnt;
        do_req(7, 80, 1'b0, 0);
        chk(rd_cnt - r0 == 0, "hit_rd_count", rd_cnt - r0, 0);
        chk(cap_lat == 1, "hit_latency", cap_lat, 1);
        chk(cap_pix == 0, "hit_pixel", cap_pix, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        r0 = rd_cnt;
        do_req(7, 80, 1'b0, 0);
        chk(rd_cnt - r0 == 1, "flush_rd_count", rd_cnt - r0, 1);
        chk(cap_lat == 3, "flush_latency", cap_lat, 3);
`endif

        mem_mode = 1'b1;
        px = 0;
        py = 80;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = px ^ int'($urandom_range(0, 15));
                y = py;
            end else begin
                x = int'($urandom_range(0, 700));
                y = int'($urandom_range(60, 500));
            end
            do_req(x, y, $urandom_range(0, 7) == 0,
                   ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 4)) : 0);
            px = x;
            py = y;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
